mul_sequencer: RTL and testbench

Multi-cycle multiply unit and write-back sequencer for the multicycle ARM core. It executes MUL, UMULL and SMULL with an iterative radix-2 shift-add engine. It then drives the single register-file write port for one write (MUL) or two consecutive writes (RdLo, then RdHi) for 64-bit results. The main FSM holds in its execute state while busy=1 and resumes on done.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/shift_add_mul.sv | 65 ++++++
 rtl/mul_sequencer.sv | 142 ++++++++++++++
 tb/tb_mul_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle core: op encodings, sequencer states
// and the default datapath width.
package cpu_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  localparam logic [1:0] MUL_OP   = 2'b00;
  localparam logic [1:0] UMULL_OP = 2'b01;
  localparam logic [1:0] SMULL_OP = 2'b10;
  localparam logic [1:0] RSV_OP   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    WBLO = 2'b10,
    WBHI = 2'b11
  } state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Radix-2 shift-add multiplier engine: load latches operand magnitudes, each step
// retires one multiplier bit, and the final step applies the sign correction.
module shift_add_mul #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 last,
  output logic [WIDTH-1:0]     prod_hi,
  output logic [2*WIDTH-1:0]   fin_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW:0]        acc;
  logic [PW:0]        acc_step;
  logic [WIDTH:0]     upper;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [CNT_W-1:0]   cnt;
  logic               neg;

  // Magnitudes for signed operands; the most negative value maps to 2^(WIDTH-1).
  always_comb begin
    a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    b_mag = (sgn && b[WIDTH-1]) ? -b : b;
  end

  // One iteration: conditional add into the upper half, then shift right.
  always_comb begin
    upper    = acc[PW:WIDTH] + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc_step = {1'b0, upper, acc[WIDTH-1:1]};
    fin_c    = neg ? -acc_step[PW-1:0] : acc_step[PW-1:0];
  end

  assign prod_hi = acc[PW-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      mcand <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      acc   <= {{(WIDTH+1){1'b0}}, a_mag};
      mcand <= b_mag;
      neg   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      cnt   <= '0;
      last  <= 1'b0;
    end else if (step) begin
      acc   <= last ? {1'b0, fin_c} : acc_step;
      cnt   <= cnt + CNT_W'(1);
      last  <= (cnt == CNT_W'(WIDTH - 2));
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multiply sequencer: runs MUL/UMULL/SMULL on the shift-add engine and drives the
// register-file write port for one or two write-back cycles.
module mul_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             setflags,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       rd_lo,
  input  logic [3:0]       rd_hi,
  input  logic             flush,
  output logic             busy,
  output logic             rf_we,
  output logic [3:0]       rf_wa,
  output logic [WIDTH-1:0] rf_wd,
  output logic             done,
  output logic             flag_we,
  output logic             flag_n,
  output logic             flag_z
);

  localparam int unsigned PW = 2 * WIDTH;

  state_t           state;
  logic [1:0]       op_q;
  logic             sf_q;
  logic [3:0]       lo_q;
  logic [3:0]       hi_q;
  logic             pend_n;
  logic             pend_z;
  logic             load_c;
  logic             step_c;
  logic             last;
  logic [WIDTH-1:0] prod_hi;
  logic [PW-1:0]    fin_c;

  assign load_c = (state == IDLE) && start && (op != RSV_OP);
  assign step_c = (state == CALC) && !flush;

  shift_add_mul #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_engine (
    .clk     (clk),
    .reset   (reset),
    .load    (load_c),
    .step    (step_c),
    .sgn     (op == SMULL_OP),
    .a       (a),
    .b       (b),
    .last    (last),
    .prod_hi (prod_hi),
    .fin_c   (fin_c)
  );

  // Sequencer; every output is registered so start never reaches rf_we combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= MUL_OP;
      sf_q    <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      pend_n  <= 1'b0;
      pend_z  <= 1'b0;
      busy    <= 1'b0;
      rf_we   <= 1'b0;
      rf_wa   <= '0;
      rf_wd   <= '0;
      done    <= 1'b0;
      flag_we <= 1'b0;
      flag_n  <= 1'b0;
      flag_z  <= 1'b0;
    end else begin
      rf_we   <= 1'b0;
      done    <= 1'b0;
      flag_we <= 1'b0;
      case (state)
        IDLE: begin
          if (load_c) begin
            op_q  <= op;
            sf_q  <= setflags;
            lo_q  <= rd_lo;
            hi_q  <= rd_hi;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (last) begin
            rf_we  <= 1'b1;
            rf_wa  <= lo_q;
            rf_wd  <= fin_c[WIDTH-1:0];
            pend_n <= fin_c[PW-1];
            pend_z <= (fin_c == '0);
            if (op_q == MUL_OP) begin
              done    <= 1'b1;
              flag_we <= sf_q;
              flag_n  <= fin_c[WIDTH-1];
              flag_z  <= (fin_c[WIDTH-1:0] == '0);
            end
            state <= WBLO;
          end
        end
        WBLO: begin
          if (flush || (op_q == MUL_OP)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            rf_we   <= 1'b1;
            rf_wa   <= hi_q;
            rf_wd   <= prod_hi;
            done    <= 1'b1;
            flag_we <= sf_q;
            flag_n  <= pend_n;
            flag_z  <= pend_z;
            state   <= WBHI;
          end
        end
        WBHI: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer with hand-computed products.
module tb_mul_sequencer;
  import cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic        setflags;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  rd_lo;
  logic [3:0]  rd_hi;
  logic        flush;
  logic        busy;
  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        done;
  logic        flag_we;
  logic        flag_n;
  logic        flag_z;

  int errors;
  int checks;

  mul_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .setflags (setflags),
    .a        (a),
    .b        (b),
    .rd_lo    (rd_lo),
    .rd_hi    (rd_hi),
    .flush    (flush),
    .busy     (busy),
    .rf_we    (rf_we),
    .rf_wa    (rf_wa),
    .rf_wd    (rf_wd),
    .done     (done),
    .flag_we  (flag_we),
    .flag_n   (flag_n),
    .flag_z   (flag_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},    64'(busy),    64'd0);
    chk({tag, "_rf_we"},   64'(rf_we),   64'd0);
    chk({tag, "_rf_wa"},   64'(rf_wa),   64'd0);
    chk({tag, "_rf_wd"},   64'(rf_wd),   64'd0);
    chk({tag, "_done"},    64'(done),    64'd0);
    chk({tag, "_flag_we"}, 64'(flag_we), 64'd0);
    chk({tag, "_flag_n"},  64'(flag_n),  64'd0);
    chk({tag, "_flag_z"},  64'(flag_z),  64'd0);
  endtask

  // Issue one operation and check the whole timeline against the expected product.
  task automatic run(input string tag, input logic [1:0] o, input logic sf,
                     input logic [31:0] av, input logic [31:0] bv,
                     input logic [3:0] lo, input logic [3:0] hi,
                     input logic [31:0] elo, input logic [31:0] ehi,
                     input logic en, input logic ez);
    int bad_busy;
    int bad_we;
    bad_busy = 0;
    bad_we   = 0;
    @(negedge clk);
    op = o; setflags = sf; a = av; b = bv; rd_lo = lo; rd_hi = hi; start = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'b1) bad_busy++;
      if (rf_we !== 1'b0 || done !== 1'b0 || flag_we !== 1'b0) bad_we++;
    end
    chk({tag, "_busy_calc"}, 64'(bad_busy), 64'd0);
    chk({tag, "_quiet_calc"}, 64'(bad_we), 64'd0);
    @(negedge clk);
    chk({tag, "_lo_we"},   64'(rf_we), 64'd1);
    chk({tag, "_lo_wa"},   64'(rf_wa), 64'(lo));
    chk({tag, "_lo_wd"},   64'(rf_wd), 64'(elo));
    chk({tag, "_lo_busy"}, 64'(busy),  64'd1);
    if (o == MUL_OP) begin
      chk({tag, "_done"},    64'(done),    64'd1);
      chk({tag, "_flag_we"}, 64'(flag_we), 64'(sf));
      chk({tag, "_flag_n"},  64'(flag_n),  64'(en));
      chk({tag, "_flag_z"},  64'(flag_z),  64'(ez));
    end else begin
      chk({tag, "_lo_done"}, 64'(done), 64'd0);
      @(negedge clk);
      chk({tag, "_hi_we"},   64'(rf_we),   64'd1);
      chk({tag, "_hi_wa"},   64'(rf_wa),   64'(hi));
      chk({tag, "_hi_wd"},   64'(rf_wd),   64'(ehi));
      chk({tag, "_done"},    64'(done),    64'd1);
      chk({tag, "_flag_we"}, 64'(flag_we), 64'(sf));
      chk({tag, "_flag_n"},  64'(flag_n),  64'(en));
      chk({tag, "_flag_z"},  64'(flag_z),  64'(ez));
    end
    @(negedge clk);
    chk({tag, "_after_busy"}, 64'(busy),  64'd0);
    chk({tag, "_after_we"},   64'(rf_we), 64'd0);
    chk({tag, "_after_done"}, 64'(done),  64'd0);
  endtask

  initial begin
    int bad;
    errors = 0; checks = 0;
    reset = 1'b1; start = 1'b0; op = 2'b00; setflags = 1'b0;
    a = '0; b = '0; rd_lo = '0; rd_hi = '0; flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;

    run("mul_7x6",    MUL_OP,   1'b1, 32'd7, 32'd6, 4'd3, 4'd0, 32'd42, 32'd0, 1'b0, 1'b0);
    run("mul_neg",    MUL_OP,   1'b1, 32'hFFFFFFFF, 32'd2, 4'd1, 4'd0, 32'hFFFFFFFE, 32'd0, 1'b1, 1'b0);
    run("mul_zlow",   MUL_OP,   1'b1, 32'h00010000, 32'h00010000, 4'd4, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    run("umull_max",  UMULL_OP, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, 4'd5, 32'h00000001, 32'hFFFFFFFE, 1'b1, 1'b0);
    run("smull_m2x3", SMULL_OP, 1'b1, 32'hFFFFFFFE, 32'd3, 4'd4, 4'd6, 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b1, 1'b0);
    run("smull_5xm7", SMULL_OP, 1'b1, 32'd5, 32'hFFFFFFF9, 4'd8, 4'd10, 32'hFFFFFFDD, 32'hFFFFFFFF, 1'b1, 1'b0);
    run("smull_min",  SMULL_OP, 1'b1, 32'h80000000, 32'h80000000, 4'd1, 4'd2, 32'h00000000, 32'h40000000, 1'b0, 1'b0);
    run("umull_z_s",  UMULL_OP, 1'b1, 32'd0, 32'h1234, 4'd11, 4'd12, 32'd0, 32'd0, 1'b0, 1'b1);
    run("umull_z_ns", UMULL_OP, 1'b0, 32'd0, 32'h1234, 4'd11, 4'd12, 32'd0, 32'd0, 1'b0, 1'b1);
    run("umull_same", UMULL_OP, 1'b0, 32'd3, 32'd4, 4'd9, 4'd9, 32'd12, 32'd0, 1'b0, 1'b0);

    // Flush in CALC, with an ignored second start along the way.
    @(negedge clk);
    op = MUL_OP; setflags = 1'b1; a = 32'd9; b = 32'd9; rd_lo = 4'd6; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 5) begin start = 1'b1; op = UMULL_OP; end
      if (c == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rf_we !== 1'b0 || done !== 1'b0 || flag_we !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("flush_quiet", 64'(bad), 64'd0);

    // Reserved op is ignored.
    @(negedge clk);
    op = RSV_OP; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rsv_busy", 64'(busy), 64'd0);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rf_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("rsv_quiet", 64'(bad), 64'd0);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    op = MUL_OP; setflags = 1'b1; a = 32'd9; b = 32'd9; rd_lo = 4'd6; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run("mul_5x5", MUL_OP, 1'b1, 32'd5, 32'd5, 4'd7, 4'd0, 32'd25, 32'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
